msk_burst_feeder: RTL
=====================

// Module: msk_burst_feeder
// PURPOSE
//  Buffers the MSK modulator's 32-bit I/Q sample stream (I=[31:16], Q=[15:0]).
//  Releases it as fixed-length downlink bursts to da_send_out in the clk_50m domain.
//  Each sample is held 2 clk_50m cycles (25 Msps), matching the DAC RAM write toggle.
//  Drives msk_iq_data / msk_data_valid / dl_data_dac_window, all coincident per burst.
// PARAMETERS
//  FIFO_AW     9    sample FIFO address width (depth 2**FIFO_AW = 512)
//  PREFILL_TH  64   FIFO samples required before a burst starts (capped at burst length)
//  GUARD_CYC   16   clk_50m cycles of forced idle after each burst (>=1)
// PORTS
//  clk_50m             in   1   system clock, 50 MHz
//  sys_rst_n           in   1   asynchronous active-low reset
//  in_iq_data          in   32  modulator sample
//  in_valid            in   1   sample present; pushed when in_valid & in_ready
//  in_ready            out  1   FIFO not full
//  burst_start         in   1   1-cycle request to send one burst
//  burst_len           in   10  samples per burst, 1..512; sampled with burst_start
//  underrun_clr        in   1   clears underrun_flag
//  test_ramp           in   1   ramp-pattern select (MSK_FEEDER_TEST_RAMP_EN only)
//  msk_iq_data         out  32  sample to DAC path, held 2 cycles
//  msk_data_valid      out  1   high for exactly 2*len cycles per burst
//  dl_data_dac_window  out  1   identical timing to msk_data_valid
//  burst_busy          out  1   state != IDLE
//  burst_done          out  1   1-cycle pulse on the last burst cycle (SEND->GUARD)
//  underrun_flag       out  1   sticky: FIFO empty when a sample was due
//  fifo_level          out  10  current FIFO occupancy, 0..512
// BEHAVIOUR
//  Reset: outputs 0 except in_ready=1; FIFO emptied; FSM=IDLE; len reg=0.
//  Reset mid-burst aborts at once: valid/window fall asynchronously; no burst_done.
//  FIFO: synchronous, show-ahead; in_ready=(level<2**FIFO_AW).
//   Push and pop on the same cycle leave the level unchanged.
//  Length: latched on burst_start in IDLE. Value 0 -> request ignored. Value >512 -> 512.
//  burst_start outside IDLE is ignored; it is not queued.
//  FSM:
//   IDLE:    burst_start & len!=0 -> PREFILL; latch len.
//   PREFILL: level >= min(len,PREFILL_TH) -> SEND. Stays in PREFILL indefinitely otherwise.
//   SEND:    phase bit toggles every cycle, starting at 0.
//            Phase 0: msk_iq_data <= FIFO head (pop) and sample count increments.
//            After phase 1 of sample len -> GUARD.
//   GUARD:   GUARD_CYC cycles with valid/window low -> IDLE.
//  Latency: with the FIFO already prefilled, burst_start sampled at edge N gives
//   valid=window=1 from edge N+2, with msk_iq_data = first sample.
//   The signals fall at edge N+2+2*len.
//  Underrun: FIFO empty at a phase-0 cycle -> sample output as 32'h0 and no pop.
//   underrun_flag set; the burst still runs its full length.
//   underrun_clr takes priority over a same-cycle set.
//  msk_iq_data returns to 0 on the cycle valid falls.
//  fifo_level is registered and reflects the pushes and pops of the previous edge.
// CONFIGURATION
//  MSK_FEEDER_TEST_RAMP_EN defined:
//   When test_ramp=1 at the SEND entry, the burst sends {cnt[15:0], ~cnt[15:0]}.
//   cnt=0..len-1. The FIFO is not popped and PREFILL is bypassed (no level check).
//  MSK_FEEDER_TEST_RAMP_EN undefined:
//   test_ramp is ignored and the ramp logic is absent.
// TESTING
//  Push 100 samples D0..D99, then burst_start with len=100.
//   -> valid/window high for 200 cycles; each Di held 2 cycles; burst_done once.
//   -> fifo_level reads 0 at the end.
//  len=512 with the FIFO full (512 samples), pushing continuously during the burst.
//   -> in_ready rises after the first pop; 1024 valid cycles; no underrun.
//  Prefill 64 samples, len=80, no further pushes.
//   -> samples 65..80 are 32'h0; underrun_flag=1 until underrun_clr.
//  burst_start during SEND, len=0 in IDLE, burst_start during GUARD -> all ignored.
//   The next legal start begins a burst only after GUARD_CYC idle cycles.
//  sys_rst_n low at cycle 37 of a burst.
//   -> valid, window, busy and fifo_level = 0 immediately; no burst_done.
//   -> After release, a new 10-sample burst runs cleanly.
//  With MSK_FEEDER_TEST_RAMP_EN, test_ramp=1, len=4.
//   -> data 0000FFFF, 0001FFFE, 0002FFFD, 0003FFFC; fifo_level unchanged.

Source files
------------

// File: rtl/msk_burst_feeder.sv
// Buffers MSK I/Q samples in a show-ahead FIFO and releases them as fixed-length
// DAC bursts, two clk_50m cycles per sample. Optional ramp source: MSK_FEEDER_TEST_RAMP_EN.
module msk_burst_feeder #(
   parameter int FIFO_AW    = 9,
   parameter int PREFILL_TH = 64,
   parameter int GUARD_CYC  = 16
) (
   input  logic             clk_50m,
   input  logic             sys_rst_n,
   input  logic [31:0]      in_iq_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             burst_start,
   input  logic [9:0]       burst_len,
   input  logic             underrun_clr,
   input  logic             test_ramp,
   output logic [31:0]      msk_iq_data,
   output logic             msk_data_valid,
   output logic             dl_data_dac_window,
   output logic             burst_busy,
   output logic             burst_done,
   output logic             underrun_flag,
   output logic [FIFO_AW:0] fifo_level
);

   localparam int                LW       = FIFO_AW + 1;
   localparam int                DEPTH    = 1 << FIFO_AW;
   localparam logic [LW-1:0]     FULL_LVL = LW'(DEPTH);
   localparam logic [9:0]        MAX_LEN  = 10'd512;
   localparam logic [9:0]        TH_L     = 10'(PREFILL_TH);
   localparam logic [15:0]       GUARD_L  = 16'(GUARD_CYC);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_PREFILL = 2'd1,
      S_SEND    = 2'd2,
      S_GUARD   = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic             phase_q, phase_d;
   logic [9:0]       len_q, len_d;
   logic [9:0]       cnt_q, cnt_d;
   logic [15:0]      guard_q, guard_d;
   logic [31:0]      data_q, data_d;
   logic             valid_q, valid_d;
   logic             done_q, done_d;
   logic             under_q, under_d;
   logic             under_set;

   logic [31:0]      mem_q [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]    level_q;
   logic             push, pop, fifo_empty;
   logic [31:0]      fifo_head;
   logic [9:0]       thr;
   logic             prefill_ok;

`ifdef MSK_FEEDER_TEST_RAMP_EN
   logic             ramp_q, ramp_d;
`else
   logic             unused_test_ramp;
   assign unused_test_ramp = test_ramp;
`endif

   assign in_ready   = (level_q < FULL_LVL);
   assign push       = in_valid & in_ready;
   assign fifo_empty = (level_q == '0);
   assign fifo_head  = mem_q[rd_ptr_q];

   // Short bursts need only their own length buffered before starting.
   assign thr        = (len_q < TH_L) ? len_q : TH_L;
   assign prefill_ok = (16'(level_q) >= 16'(thr));

   always_ff @(posedge clk_50m) begin
      if (push) mem_q[wr_ptr_q] <= in_iq_data;
   end

   always_ff @(posedge clk_50m or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push && !pop)      level_q <= level_q + 1'b1;
         else if (!push && pop) level_q <= level_q - 1'b1;
      end
   end

   always_ff @(posedge clk_50m or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= S_IDLE;
         phase_q <= 1'b0;
         len_q   <= '0;
         cnt_q   <= '0;
         guard_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         under_q <= 1'b0;
`ifdef MSK_FEEDER_TEST_RAMP_EN
         ramp_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         guard_q <= guard_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         under_q <= under_d;
`ifdef MSK_FEEDER_TEST_RAMP_EN
         ramp_q  <= ramp_d;
`endif
      end
   end

   // Outputs are registered one cycle behind the state, so valid trails SEND by one edge.
   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      guard_d   = guard_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      done_d    = 1'b0;
      under_set = 1'b0;
      pop       = 1'b0;
`ifdef MSK_FEEDER_TEST_RAMP_EN
      ramp_d    = ramp_q;
`endif
      case (state_q)
         S_IDLE: begin
            data_d = '0;
            if (burst_start && (burst_len != 10'd0)) begin
               len_d   = (burst_len > MAX_LEN) ? MAX_LEN : burst_len;
               state_d = S_PREFILL;
            end
         end
         S_PREFILL: begin
            data_d = '0;
`ifdef MSK_FEEDER_TEST_RAMP_EN
            if (test_ramp || prefill_ok) begin
               ramp_d  = test_ramp;
               state_d = S_SEND;
               phase_d = 1'b0;
               cnt_d   = '0;
            end
`else
            if (prefill_ok) begin
               state_d = S_SEND;
               phase_d = 1'b0;
               cnt_d   = '0;
            end
`endif
         end
         S_SEND: begin
            valid_d = 1'b1;
            phase_d = ~phase_q;
            if (!phase_q) begin
               cnt_d = cnt_q + 10'd1;
`ifdef MSK_FEEDER_TEST_RAMP_EN
               if (ramp_q) begin
                  data_d = {{6'd0, cnt_q}, ~{6'd0, cnt_q}};
               end else
`endif
               if (fifo_empty) begin
                  data_d    = '0;
                  under_set = 1'b1;
               end else begin
                  data_d = fifo_head;
                  pop    = 1'b1;
               end
            end else if (cnt_q == len_q) begin
               state_d = S_GUARD;
               done_d  = 1'b1;
               guard_d = '0;
            end
         end
         S_GUARD: begin
            data_d  = '0;
            guard_d = guard_q + 16'd1;
            // GUARD also covers the trailing valid cycle, hence the extra count.
            if (guard_q == GUARD_L) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            data_d  = '0;
         end
      endcase
      under_d = underrun_clr ? 1'b0 : (under_q | under_set);
   end

   assign msk_iq_data        = data_q;
   assign msk_data_valid     = valid_q;
   assign dl_data_dac_window = valid_q;
   assign burst_busy         = (state_q != S_IDLE);
   assign burst_done         = done_q;
   assign underrun_flag      = under_q;
   assign fifo_level         = level_q;

endmodule
